// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM state encoding,
// parity modes and frame-length arithmetic.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  // Total bits on the line for one frame, start bit included.
  function automatic logic [3:0] frame_len(input int data_bits, input int parity_en,
                                           input int stop_bits);
    int n;
    n = data_bits + parity_en + stop_bits + 32'sd1;
    return n[3:0];
  endfunction

  // Parity bit a transmitter would send; unused upper data bits must be zero.
  function automatic logic parity_bit(input logic [8:0] data, input logic [1:0] mode);
    return (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial input; resets to the
// idle (high) line level so no false start is seen coming out of reset.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive engine: start-bit qualification on the oversampled tick,
// data/parity/stop sampling, and a one-deep valid/ready output register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sel,
  input  logic                 rx_en,
  input  logic                 baud_tick,
  input  logic                 rxd,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [3:0]           bit_cnt
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 32'sd2 - 32'sd1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 32'sd1);
  localparam logic [TW-1:0] TICK_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS);
  localparam logic [3:0]    STOP_LAST = frame_len(DATA_BITS, PARITY_EN, STOP_BITS) - 4'd1;
  localparam logic [1:0]    PAR_MODE  = (PARITY_EN == 0) ? PAR_NONE :
                                        ((PARITY_ODD == 0) ? PAR_EVEN : PAR_ODD);

  logic                 rxs_s;
  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d, tick_inc_s;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pe_q, pe_d, fe_q, fe_d;
  logic                 rxs_prev_q;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q;
  logic                 sample_s, done_s, fe_now_s;
  logic [8:0]           data9_s;

  uart_rx_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxs_s)
  );

  // Next-state, bit sampling and output-register update
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    data_d    = data_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    ovr_d     = 1'b0;
    done_s    = 1'b0;
    fe_now_s  = fe_q | ~rxs_s;
    data9_s   = 9'd0;
    data9_s[DATA_BITS-1:0] = shift_q;
    // The start bit is checked at half a period; every later bit one full period on.
    sample_s   = baud_tick && (tick_q == ((state_q == ST_START) ? TICK_MID : TICK_LAST));
    tick_inc_s = baud_tick ? (tick_q + TICK_ONE) : tick_q;

    if (valid_q && rx_ready) valid_d = 1'b0;
    else                     valid_d = valid_q;

    if (!(sel && rx_en)) begin
      state_d   = ST_IDLE;
      tick_d    = '0;
      bit_cnt_d = 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tick_d    = '0;
          bit_cnt_d = 4'd0;
          if (rxs_prev_q && !rxs_s) begin
            state_d = ST_START;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (!sample_s) begin
            tick_d = tick_inc_s;
          end else if (rxs_s) begin
            state_d = ST_IDLE;
            tick_d  = '0;
          end else begin
            state_d   = ST_DATA;
            tick_d    = '0;
            bit_cnt_d = 4'd1;
          end
        end
        ST_DATA: begin
          if (!sample_s) begin
            tick_d = tick_inc_s;
          end else begin
            tick_d    = '0;
            shift_d   = {rxs_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == DATA_LAST) state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            else                        state_d = ST_DATA;
          end
        end
        ST_PARITY: begin
          if (!sample_s) begin
            tick_d = tick_inc_s;
          end else begin
            tick_d    = '0;
            bit_cnt_d = bit_cnt_q + 4'd1;
            state_d   = ST_STOP;
            if (rxs_s != parity_bit(data9_s, PAR_MODE)) pe_d = 1'b1;
            else                                         pe_d = pe_q;
          end
        end
        ST_STOP: begin
          if (!sample_s) begin
            tick_d = tick_inc_s;
          end else begin
            tick_d = '0;
            if (bit_cnt_q == STOP_LAST) begin
              state_d   = ST_IDLE;
              bit_cnt_d = 4'd0;
              done_s    = 1'b1;
            end else begin
              fe_d      = fe_now_s;
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        default: begin
          state_d   = ST_IDLE;
          tick_d    = '0;
          bit_cnt_d = 4'd0;
        end
      endcase
    end

    // A finished frame loads only if the held one is gone or leaves this cycle.
    if (done_s && (!valid_q || rx_ready)) begin
      data_d  = shift_q;
      ferr_d  = fe_now_s;
      perr_d  = pe_q;
      valid_d = 1'b1;
    end else if (done_s) begin
      ovr_d = 1'b1;
    end else begin
      ovr_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      rxs_prev_q <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovr_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      rxs_prev_q <= rxs_s;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      ovr_q      <= ovr_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign rx_data    = data_q;
  assign rx_valid   = valid_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
  assign busy       = busy_q;
  assign bit_cnt    = bit_cnt_q;

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receive engine, next generation of the receive bit-counter logic in the UART block. It synchronises the serial input, detects and qualifies the start bit on an oversampled baud tick, and shifts in a configurable number of data bits with optional parity and one or two stop bits. It then presents each frame through a one-deep valid/ready output register with framing, parity and overrun status. It sits between the baud generator (tick source) and the UART register/FIFO interface.

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9
- OVERSAMPLE, 16, baud_tick pulses per bit period, even, legal 8..32
- PARITY_EN, 0, 1 = a parity bit follows the data
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0)
- STOP_BITS, 1, legal 1 or 2

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sel  in  1  block select; 0 = standby
- rx_en  in  1  receive enable; 0 = idle
- baud_tick  in  1  single-cycle enable at OVERSAMPLE x baud rate
- rxd  in  1  asynchronous serial input, idle high
- rx_ready  in  1  consumer accepts rx_data
- rx_data  out  DATA_BITS  received data, LSB first on the line
- rx_valid  out  1  rx_data and its error flags are held
- frame_err  out  1  a stop bit sampled low (qualifies rx_data)
- parity_err  out  1  parity mismatch (qualifies rx_data)
- overrun  out  1  one-cycle pulse: a frame completed while rx_valid=1 and rx_ready=0
- busy  out  1  FSM not in IDLE
- bit_cnt  out  4  index of the current bit: 0 = start, 1..DATA_BITS = data, then parity, then stop

## Operation
- rxd passes through a 2-flop synchroniser (reset value 1). All sampling uses the synchronised signal rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP. Only baud_tick advances the tick counter (0..OVERSAMPLE-1). The tick counter clears on every state entry.
- IDLE: a falling rxs (1->0) with sel=1 and rx_en=1 -> START.
- START: at tick OVERSAMPLE/2-1 (mid-bit), rxs=1 -> false start, return to IDLE; rxs=0 -> clear the tick counter and enter DATA.
- DATA: sample at the tick that completes each bit period (which is mid-bit) and shift right into a shift register. After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY: sample one bit and compare it with the XOR of the data bits (inverted if PARITY_ODD). A mismatch latches pe_int.
- STOP: sample STOP_BITS bits. Any stop bit sampled 0 latches fe_int. The FSM always consumes all STOP_BITS bits, then returns to IDLE on the final stop sample.
- Completion on the final stop sample:
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 on the same cycle: load rx_data/frame_err/parity_err and set rx_valid.
  - Otherwise: discard the new frame, keep the held data, and pulse overrun.
- Handshake: rx_valid stays 1 until a cycle with rx_ready=1. It clears on that cycle unless a completion coincides, in which case the new frame loads and rx_valid stays 1.
- sel=0 or rx_en=0 at any point: FSM forced to IDLE and tick/bit counters cleared. A partial frame is dropped silently. The held output register and rx_valid are unaffected.
- bit_cnt saturates at its final stop index until IDLE, then returns to 0.

## Timing
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun=0, busy=0, bit_cnt=0, FSM=IDLE.
- Input latency: 2 clk from rxd edge to rxs.
- Output latency: rx_valid rises on the clk edge after the baud_tick cycle of the final stop-bit sample. overrun pulses on that same edge.
- Start-edge resolution: up to 1 baud_tick, plus synchroniser delay.
- A falling edge during STOP is not recognised until the FSM has entered IDLE.
- Reset asserted mid-frame: all state returns immediately to reset values.

## Structure
- Package uart_pkg holds:
  - the rx state enum
  - the parity-mode constants
  - a function returning frame length in bits: 1 + DATA_BITS + PARITY_EN + STOP_BITS
- Sub-module uart_rx_sync: 2-flop synchroniser with reset-to-1. Everything else stays in one module.

## Test plan
- 8N1, OVERSAMPLE=16, send 0xA5 with rx_ready=1 -> rx_data=0xA5, one-cycle rx_valid, no errors, bit_cnt sequence 0..9.
- 7E1, send 0x35 with a wrong parity bit -> rx_data=0x35, parity_err=1; correct parity bit -> parity_err=0.
- 8N2, second stop bit driven 0 -> frame_err=1, and the FSM still consumes both stop bits before IDLE.
- rxd low pulse of 4 baud_ticks -> false start, busy returns to 0, no rx_valid.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once, rx_valid held until rx_ready.
- Deassert rx_en at bit 4 of a frame, then send 0x5A -> first frame dropped, 0x5A received cleanly; rst_n pulsed mid-frame -> all outputs return to reset values.
